// File: rtl/fetch_sequencer.sv
// Dual-issue fetch front end: issues ROM reads against free queue space, buffers bundles, presents two {inst,pc} to decode.
// Decode sees data 2 cycles after enable; stalls issue when the queue could overflow; FETCH_SEQ_PERF_EN adds perf counters.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          QDEPTH   = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  output logic             o_rom_en,
  output logic [31:0]      o_fetch_pc,
  input  logic [1:0][31:0] i_rom_insts,
  input  logic             i_redirect,
  input  logic [31:0]      i_redirect_pc,
  output logic [1:0][31:0] o_dec_insts,
  output logic [1:0][31:0] o_dec_pcs,
  output logic [1:0]       o_dec_valid,
  input  logic [1:0]       i_dec_take
`ifdef FETCH_SEQ_PERF_EN
  ,
  output logic [31:0]      o_full_stall_cycles,
  output logic [31:0]      o_redirect_count,
  output logic [31:0]      o_fetched_bundles
`endif
);

  localparam int AW = $clog2(QDEPTH);
  localparam int CW = AW + 1;
  typedef logic [AW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;
  localparam logic [CW:0] ISSUE_LIMIT = (CW+1)'(QDEPTH - 2);

  logic [31:0] pc_q, pc_d;
  logic [31:0] inflight_pc_q, inflight_pc_d;
  logic        inflight_q, inflight_d;
  ptr_t        head_q, head_d, tail_q, tail_d;
  cnt_t        count_q, count_d;
  logic [CW:0] occupancy;
  logic        push;
  ptr_t        head_nx, tail_nx;

  logic [31:0] inst_mem [QDEPTH];
  logic [31:0] pc_mem   [QDEPTH];

  // Occupancy counts the in-flight bundle as already queued, so a response always has room.
  always_comb begin
    occupancy     = {1'b0, count_q} + (inflight_q ? (CW+1)'(2) : '0);
    o_rom_en      = i_rst_n && !i_redirect && (occupancy <= ISSUE_LIMIT);
    push          = inflight_q && !i_redirect;
    pc_d          = pc_q;
    inflight_d    = o_rom_en;
    inflight_pc_d = inflight_pc_q;
    head_d        = head_q;
    tail_d        = tail_q;
    count_d       = count_q;
    if (i_redirect) begin
      pc_d    = i_redirect_pc;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (o_rom_en) begin
        inflight_pc_d = pc_q;
        pc_d          = pc_q + 32'd8;
      end
      head_d  = head_q + ptr_t'(i_dec_take);
      if (push) tail_d = tail_q + ptr_t'(2);
      count_d = count_q + (push ? cnt_t'(2) : '0) - cnt_t'(i_dec_take);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
    end else begin
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
    end
  end

  assign tail_nx = tail_q + ptr_t'(1);
  assign head_nx = head_q + ptr_t'(1);

  always_ff @(posedge i_clk) begin
    if (push) begin
      inst_mem[tail_q]  <= i_rom_insts[0];
      inst_mem[tail_nx] <= i_rom_insts[1];
      pc_mem[tail_q]    <= inflight_pc_q;
      pc_mem[tail_nx]   <= inflight_pc_q + 32'd4;
    end
  end

  assign o_fetch_pc     = pc_q;
  assign o_dec_insts[0] = inst_mem[head_q];
  assign o_dec_insts[1] = inst_mem[head_nx];
  assign o_dec_pcs[0]   = pc_mem[head_q];
  assign o_dec_pcs[1]   = pc_mem[head_nx];
  assign o_dec_valid    = {count_q >= cnt_t'(2), count_q != '0};

`ifdef FETCH_SEQ_PERF_EN
  logic [31:0] stall_q, redir_q, fetched_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      stall_q   <= '0;
      redir_q   <= '0;
      fetched_q <= '0;
    end else begin
      if (!o_rom_en && !i_redirect && stall_q != '1) stall_q <= stall_q + 32'd1;
      if (i_redirect && redir_q != '1)               redir_q <= redir_q + 32'd1;
      if (push && fetched_q != '1)                   fetched_q <= fetched_q + 32'd1;
    end
  end

  assign o_full_stall_cycles = stall_q;
  assign o_redirect_count    = redir_q;
  assign o_fetched_bundles   = fetched_q;
`endif

  a_take_legal: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    i_redirect || (i_dec_take != 2'd3 && cnt_t'(i_dec_take) <= count_q));
  a_count_max: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    count_q <= cnt_t'(QDEPTH));

endmodule
